// File: rtl/spi_peripheral.sv
// Write-only SPI target (mode 0) for the PWM configuration registers.
// SCLK/COPI/nCS are synchronised into the clk domain. 16-bit frames
// (R/W, 7-bit address, 8-bit data; MSB first) are decoded and written
// to one of five 8-bit registers.
module spi_peripheral #(
    parameter logic [6:0] MAX_ADDR = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [4:0] CNT_FULL    = 5'd16;
    localparam logic [4:0] CNT_OVERRUN = 5'd17;

    // Synchroniser chains (s1 -> s2, plus s3 on sclk/ncs for edge detection)
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic copi_s1_q, copi_s2_q;
    logic ncs_s1_q, ncs_s2_q, ncs_s3_q;

    logic sclk_rise;
    logic ncs_rise;

    state_e      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wr_en;

    logic [7:0] out_7_0_q, out_15_8_q, pwm_7_0_q, pwm_15_8_q, duty_q;

    // Two-flop synchronisers plus one edge-detect stage.
    // ncs chains reset to the deasserted (high) level so that leaving reset
    // never looks like a chip-select edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            copi_s1_q <= 1'b0;
            copi_s2_q <= 1'b0;
            ncs_s1_q  <= 1'b1;
            ncs_s2_q  <= 1'b1;
            ncs_s3_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value; blocking ones would collapse the chain.
            sclk_s1_q <= sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            copi_s1_q <= copi;
            copi_s2_q <= copi_s1_q;
            ncs_s1_q  <= ncs;
            ncs_s2_q  <= ncs_s1_q;
            ncs_s3_q  <= ncs_s2_q;
        end
    end

    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign ncs_rise  = ncs_s2_q & ~ncs_s3_q;

    // FSM state, shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: receive bits while selected, decide the write on
    // chip-select release. The register write lands on the edge that enters
    // COMMIT, which is edge N+2 after ncs is first sampled high.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                shift_d = '0;
                cnt_d   = '0;
                if (!ncs_s2_q) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                    wr_en   = (cnt_q == CNT_FULL) && shift_q[15] &&
                              (shift_q[14:8] <= MAX_ADDR);
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s2_q};
                    if (cnt_q != CNT_OVERRUN) cnt_d = cnt_q + 5'd1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Configuration registers: only the addressed register is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these five registers are the block's visible state and
            // must read 0x00 out of reset, so each one is explicitly reset.
            out_7_0_q  <= 8'h00;
            out_15_8_q <= 8'h00;
            pwm_7_0_q  <= 8'h00;
            pwm_15_8_q <= 8'h00;
            duty_q     <= 8'h00;
        end else if (wr_en) begin
            case (shift_q[14:8])
                7'h00:   out_7_0_q  <= shift_q[7:0];
                7'h01:   out_15_8_q <= shift_q[7:0];
                7'h02:   pwm_7_0_q  <= shift_q[7:0];
                7'h03:   pwm_15_8_q <= shift_q[7:0];
                7'h04:   duty_q     <= shift_q[7:0];
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = out_7_0_q;
    assign en_reg_out_15_8 = out_15_8_q;
    assign en_reg_pwm_7_0  = pwm_7_0_q;
    assign en_reg_pwm_15_8 = pwm_15_8_q;
    assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard testbench for spi_peripheral: frames are driven on the SPI pins,
// a register-map model predicts each output change and when it must appear,
// and a monitor compares every observed output change against the queue.
module tb_spi_peripheral;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_peripheral dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle)
    );

    always #5 clk = ~clk;

    // All five outputs packed as {reg4, reg3, reg2, reg1, reg0}
    logic [39:0] dut_vec;
    assign dut_vec = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                      en_reg_out_15_8, en_reg_out_7_0};

    typedef struct {
        logic [39:0] vec;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] model [5];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [39:0] act, input logic [39:0] req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [39:0] model_vec();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    // Monitor: every output change must match the oldest predicted change.
    logic [39:0] prev_vec = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vec = dut_vec;
        end else if (dut_vec !== prev_vec) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_change", dut_vec, prev_vec);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(dut_vec === e.vec, "reg_value", dut_vec, e.vec);
                check(cyc == e.cyc, "write_latency", 40'(cyc), 40'(e.cyc));
            end
            prev_vec = dut_vec;
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        ncs  = 1'b1;
        sclk = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        check(dut_vec === 40'h0, "reset_outputs", dut_vec, 40'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Drive one frame of nbits (15: truncated, 16: normal, 17: one extra bit).
    // rst_after >= 0 interrupts the frame with a reset after that many bits.
    task automatic send_frame(input logic [15:0] frame, input int nbits, input int rst_after);
        int edge_n;
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_after) begin
                pulse_reset();
                return;
            end
            copi = (i < 16) ? frame[15 - i] : 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        edge_n = cyc + 1;
        // Reference: only complete 16-bit writes to an existing register count.
        if (nbits == 16 && frame[15] && frame[14:8] <= 7'h04) begin
            if (model[frame[10:8]] != frame[7:0]) begin
                exp_t e;
                model[frame[10:8]] = frame[7:0];
                e.vec = model_vec();
                e.cyc = edge_n + 2;
                exp_q.push_back(e);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    function automatic logic [15:0] wr(input logic [6:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        repeat (5) @(negedge clk);
        check(dut_vec === 40'h0, "reset_values", dut_vec, 40'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check(dut_vec === 40'h0, "after_reset_release", dut_vec, 40'h0);

        // Single write, then the rest of the map
        send_frame(wr(7'h00, 8'hF0), 16, -1);
        send_frame(wr(7'h01, 8'hA5), 16, -1);
        send_frame(wr(7'h02, 8'h3C), 16, -1);
        send_frame(wr(7'h03, 8'hFF), 16, -1);
        send_frame(wr(7'h04, 8'h80), 16, -1);
        check(dut_vec === 40'h80FF3CA5F0, "full_map", dut_vec, 40'h80FF3CA5F0);

        // Rejected frames: read, address just above range, top address
        send_frame({1'b0, 7'h04, 8'h11}, 16, -1);
        send_frame(wr(7'h05, 8'h22), 16, -1);
        send_frame(wr(7'h7F, 8'h33), 16, -1);

        // Malformed frames, then the valid one
        send_frame(wr(7'h04, 8'h55), 15, -1);
        send_frame(wr(7'h04, 8'h55), 17, -1);
        check(pwm_duty_cycle === 8'h80, "malformed_dropped", 40'(pwm_duty_cycle), 40'h80);
        send_frame(wr(7'h04, 8'h55), 16, -1);

        // Reset mid-frame, then a fresh frame
        send_frame(wr(7'h02, 8'h0F), 16, 8);
        check(en_reg_pwm_7_0 === 8'h00, "pwm_7_0_after_reset", 40'(en_reg_pwm_7_0), 40'h0);
        send_frame(wr(7'h02, 8'h0F), 16, -1);
        check(en_reg_pwm_7_0 === 8'h0F, "pwm_7_0_after_frame", 40'(en_reg_pwm_7_0), 40'h0F);

        // Randomised traffic
        for (int k = 0; k < 25; k++) begin
            logic [15:0] f;
            int nb;
            int sel;
            f[15]   = ($urandom_range(0, 7) != 0);
            sel     = $urandom_range(0, 9);
            f[14:8] = (sel == 9) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            f[7:0]  = 8'($urandom);
            sel     = $urandom_range(0, 9);
            nb      = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            send_frame(f, nb, -1);
        end

        repeat (10) @(negedge clk);
        check(exp_q.size() == 0, "pending_writes", 40'(exp_q.size()), 40'h0);
        check(dut_vec === model_vec(), "final_state", dut_vec, model_vec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

Write-only SPI target (mode 0) that sits directly upstream of the PWM peripheral in the TinyTapeout top level. It samples the asynchronous SCLK/COPI/nCS pins with the system clock and decodes 16-bit write transactions. It drives the five configuration registers that the PWM block consumes: output enables, PWM enables and the duty cycle. There is no read-back path and no COPI echo.

## Interface
- MAX_ADDR, default 7'h04: highest writable register address; writes above it are discarded.
- clk  input  1  system clock; every flop in the block is clocked by its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock pin (ui_in[0]), asynchronous to clk.
- copi  input  1  SPI data-in pin (ui_in[1]), asynchronous to clk.
- ncs  input  1  SPI chip select pin (ui_in[2]), active low, asynchronous to clk.
- en_reg_out_7_0  output  8  register 0x00, output enables for out[7:0].
- en_reg_out_15_8  output  8  register 0x01, output enables for out[15:8].
- en_reg_pwm_7_0  output  8  register 0x02, PWM mode enables for out[7:0].
- en_reg_pwm_15_8  output  8  register 0x03, PWM mode enables for out[15:8].
- pwm_duty_cycle  output  8  register 0x04, duty cycle (0x00 = 0%, 0xFF = 100%).

## Operation
- **Synchronisers.** Each of sclk, copi and ncs passes through a 2-flop synchroniser, giving s2. A third flop on sclk and on ncs (s3) is used for edge detection.
  - sclk rise = s2 & ~s3.
  - ncs rise = s2 & ~s3.
  - copi is sampled from its s2 stage.
- **Frame format.** 16 bits, MSB first, shifted on each synchronised sclk rise while ncs_s2 = 0.
  - bit 15: R/W (1 = write, 0 = read).
  - bits 14:8: address.
  - bits 7:0: data.
- **State machine.**
  - IDLE: ncs_s2 = 1. Clears the shift register and the bit counter. Goes to RECV when ncs_s2 = 0.
  - RECV: shifts one bit per sclk rise. The 5-bit counter increments and saturates at 17, where 17 means overrun. Goes to COMMIT on ncs rise.
  - COMMIT: lasts one cycle. Updates a register if count == 16, bit 15 == 1 and address <= MAX_ADDR. Otherwise the frame is dropped. Always returns to IDLE.
- **Discarded frames.** All of the following leave every register unchanged:
  - reads;
  - short frames (fewer than 16 bits);
  - long frames (more than 16 bits);
  - out-of-range addresses.
- **Back-to-back frames.** A new frame that starts while the block is in COMMIT is handled correctly, because the counter is cleared on entering RECV.
- **Reset.** rst_n low at any time, including mid-frame, immediately clears all five outputs to 8'h00, empties the synchronisers, clears the shift register and counter, and forces IDLE. A frame interrupted by reset is lost.
- The registers hold their value until the next valid write to that address. No other register is disturbed by a write.

## Timing
- Reset value of every output: 8'h00.
- Input synchronisation latency: 2 clk cycles.
- Write latency: let N be the first clk edge that samples ncs high. The target register changes on edge N+2 and is visible after that edge. No other output changes.
- SPI constraints, which the block relies on:
  - sclk high time and low time are each at least 3 clk periods;
  - ncs is held low at least 3 clk periods before the first sclk rise and after the last one;
  - ncs is held high at least 4 clk periods between frames;
  - copi is stable from at least 3 clk periods before each sclk rise.
- Violating these constraints may lose bits. Such frames fall into the short or long frame rule and are dropped.
- Outputs are registered and glitch-free, so they feed the PWM peripheral directly.

## Test plan
- **Reset values:** assert rst_n low for 5 cycles, then release -> all five outputs read 8'h00.
- **Single write:** write 0x00 <- 0xF0 -> en_reg_out_7_0 = 8'hF0 exactly 2 cycles after ncs_s1 first samples 1, and the other four outputs stay 8'h00.
- **Full register map:** write 0x01 <- 0xA5, 0x02 <- 0x3C, 0x03 <- 0xFF, 0x04 <- 0x80 back to back -> each register holds its value, and register 0x00 keeps its earlier value.
- **Rejected frames:** send a read 0x04 with data 0x11, a write to 0x05 <- 0x22, and a write to 0x7F <- 0x33 -> no output changes.
- **Malformed frames:** send a write to 0x04 <- 0x55 truncated at 15 bits, then the same write padded to 17 bits -> pwm_duty_cycle is unchanged in both cases; a following valid 16-bit write of 0x55 lands.
- **Reset mid-operation:** pulse rst_n low after 8 bits of a write 0x02 <- 0x0F, then send a full write 0x02 <- 0x0F -> en_reg_pwm_7_0 = 8'h00 after the pulse and 8'h0F after the fresh frame.
